// File: rtl/led_counter_top_if.sv
// LED drive bundle for led_counter_top: the counter drives it, the board pins receive it.
interface led_counter_top_if;
  logic [5:0] led;

  modport master (output led);
  modport slave  (input  led);
endinterface

// File: rtl/led_counter_top.sv
// Tang Nano 9k LED counter: free-running prescaler steps a 6-bit counter shown on active-low LEDs.
// Optional macro LED_COUNTER_GRAY_EN shows the count in Gray code instead of binary.
module led_counter_top #(
  parameter int unsigned CLK_DIV = 13_500_000
) (
  input  logic               clk,
  input  logic               rst,
  led_counter_top_if.master  bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1) begin : g_bad_clk_div
      $fatal(1, "led_counter_top: CLK_DIV must be at least 1");
    end
  endgenerate

  // Power-up values give all-LEDs-off before the first reset edge.
  logic [DIV_W-1:0] div_cnt = '0;
  logic [5:0]       cnt     = '0;
  logic             tick;
  logic [5:0]       disp;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      cnt     <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      cnt     <= cnt + 6'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

`ifdef LED_COUNTER_GRAY_EN
  assign disp = cnt ^ (cnt >> 1);
`else
  assign disp = cnt;
`endif

  assign bus.led = ~disp;

endmodule

// File: tb/tb_led_counter_top.sv
// Scoreboard bench for led_counter_top: two instances (CLK_DIV 1 and 4) checked against an edge-count model.
module tb_led_counter_top;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  led_counter_top_if bus1 ();
  led_counter_top_if bus4 ();

  led_counter_top #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  led_counter_top #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic [5:0] e1;
    logic [5:0] e4;
    bit         adv;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   k        = 0;   // rising edges with rst low since the last reset edge

  // Counter value is the number of whole prescale periods elapsed, modulo 64.
  function automatic logic [5:0] led_of(input int edges, input int div);
    logic [5:0] d;
    d = 6'((edges / div) % 64);
`ifdef LED_COUNTER_GRAY_EN
    d = d ^ (d >> 1);
`endif
    return ~d;
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r);
    exp_t e;
    rst = r;
    @(posedge clk);
    if (r) k = 0;
    else   k++;
    e.e1  = led_of(k, 1);
    e.e4  = led_of(k, 4);
    e.adv = !r;
    q.push_back(e);
    @(negedge clk);
  endtask

  exp_t       m;
  logic [5:0] prev1;
  bit         have_prev = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      check("led_div1", bus1.led, m.e1);
      check("led_div4", bus4.led, m.e4);
`ifdef LED_COUNTER_GRAY_EN
      if (m.adv && have_prev) begin
        n_checks++;
        if ($countones(bus1.led ^ prev1) != 1) begin
          n_fail++;
          $display("FAIL gray_one_flip at %0t: prev %b now %b", $time, prev1, bus1.led);
        end
      end
`endif
      prev1     = bus1.led;
      have_prev = 1;
    end
  end

  initial begin
    #1;
    check("power_up_div1", bus1.led, 6'b111111);
    check("power_up_div4", bus4.led, 6'b111111);

    @(negedge clk);
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 70; i++) step(1'b0);

    // Reset when the div-4 counter sits at cnt=5, div_cnt=2.
    step(1'b1);
    for (int i = 0; i < 22; i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);

    // Reset held across many would-be ticks.
    for (int i = 0; i < 12; i++) step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);

    for (int i = 0; i < 400; i++) step($urandom_range(0, 39) == 0);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_counter_top.md
# led_counter_top

Top-level LED counter for the Tang Nano 9k board. A free-running prescaler divides the board clock into a slow tick; each tick advances a 6-bit counter whose value is shown on the six on-board LEDs. The LEDs are active-low. This is the whole design; no other blocks sit above it.

## Interface
- CLK_DIV, default 13_500_000, is the number of clk cycles per counter step (0.5 s at 27 MHz). It must be 1 or more. A value of 0 is illegal and stops elaboration.
- clk  input  1  board clock, 27 MHz; every register updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- led  output  6  LED drive, active-low (0 = LED lit). led[0] is the LSB.

## Operation
- Prescaler div_cnt:
  - Width is max(1, $clog2(CLK_DIV)).
  - Counts 0 .. CLK_DIV-1, then wraps to 0.
  - tick is high in the cycle where div_cnt == CLK_DIV-1.
  - With CLK_DIV = 1, div_cnt stays 0 and tick is high every cycle.
- Counter cnt (6 bits):
  - On tick, cnt <= cnt + 1 modulo 64, so 63 wraps to 0.
  - The carry is discarded; no flag is generated.
- Output:
  - led = ~disp, combinational from registers only; no input-to-output path.
  - disp = cnt by default (see Configuration).
- Reset, applied on a rising edge while rst = 1:
  - div_cnt = 0 and cnt = 0.
  - led is 6'b111111, so all LEDs are off.
  - Reset takes priority over tick in the same cycle.
  - Reset mid-count abandons the partial prescale period. It does not hold the previous value.
- Before the first reset edge, register contents are don't-care. Simulation initializes all registers to 0 so led = 6'b111111 from time 0.

## Timing
- Take edge E0 as the first rising edge where rst is sampled low after reset.
- cnt becomes 1 at edge E0 + (CLK_DIV-1).
- After that, cnt advances every CLK_DIV edges.
- led changes in the same cycle as cnt, with zero extra latency.
- Full wrap period is 64 × CLK_DIV cycles. At the default this is 32 s.
- Single clock domain; no handshakes.

## Configuration
- Macro LED_COUNTER_GRAY_EN:
  - Defined: disp = cnt ^ (cnt >> 1), Gray code, so exactly one LED toggles per step. Reset still gives led = 6'b111111.
  - Undefined (default): disp = cnt, plain binary.
- Prescaler and counter behaviour are identical in both builds.

## Test plan
- CLK_DIV=1, rst high for 2 edges, then low:
  - led = 6'b111111 during reset.
  - After 3 edges, led = ~6'd3 = 6'b111100.
  - After 10 edges, led = ~6'd10.
- CLK_DIV=1, run 64 edges from reset: cnt reaches 63 (led = 6'b000000), then wraps to 0 (led = 6'b111111) on the next edge.
- CLK_DIV=4:
  - led stays 6'b111111 for the first 3 edges after reset release.
  - led becomes 6'b111110 on edge 4.
  - led becomes 6'b111101 on edge 8.
- CLK_DIV=4, assert rst for 1 cycle when cnt = 5 and div_cnt = 2:
  - The next edge gives led = 6'b111111.
  - The next step occurs 4 edges after release.
- CLK_DIV=1 with LED_COUNTER_GRAY_EN: cnt 0..7 gives disp 0, 1, 3, 2, 6, 7, 5, 4. Check that exactly one led bit flips per edge.
- rst held high while tick would fire: cnt stays 0 and led stays 6'b111111 for the whole duration.
